// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem read, holds one instruction for decode; fetch counter built only with `IFETCH_CNT_EN.
// Latency: with a same-cycle ack, inst_valid rises one cycle after the request; at most one instruction per two cycles.
// Backpressure: stall holds the instruction and blocks the next request; redirect overrides stall and ack.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h6800_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic        inst_valid,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {S_FETCH, S_DROP, S_VALID} state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] drop_addr_q;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (redirect)      state_d = imem_ack ? S_FETCH : S_DROP;
                else if (imem_ack) state_d = S_VALID;
            end
            S_DROP:  if (imem_ack) state_d = S_FETCH;
            S_VALID: if (redirect || !stall) state_d = S_FETCH;
            default: state_d = S_FETCH;
        endcase
    end

    // A killed request keeps presenting its original address until memory acks it.
    always_comb begin
        imem_req  = rst_n && (state_q != S_VALID);
        imem_addr = (state_q == S_DROP) ? drop_addr_q : fetch_pc_q;
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        inst_d     = inst_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        if (redirect) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            valid_d    = 1'b0;
            inst_d     = NOP_INST;
        end else if (state_q == S_FETCH && imem_ack) begin
            inst_d     = imem_rdata;
            pc_d       = fetch_pc_q;
            valid_d    = 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
        end else if (state_q == S_VALID && !stall) begin
            valid_d    = 1'b0;
            inst_d     = NOP_INST;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q  <= RESET_PC;
            drop_addr_q <= RESET_PC;
            inst_q      <= NOP_INST;
            pc_q        <= 32'd0;
            valid_q     <= 1'b0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            if (state_q == S_FETCH) drop_addr_q <= fetch_pc_q;
            inst_q      <= inst_d;
            pc_q        <= pc_d;
            valid_q     <= valid_d;
        end
    end

    assign inst       = inst_q;
    assign pc         = pc_q;
    assign inst_valid = valid_q;

`ifdef IFETCH_CNT_EN
    logic [31:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                count_q <= 32'd0;
        else if (valid_q && !stall && !redirect)   count_q <= count_q + 32'd1;
    end

    assign fetch_count = count_q;
`else
    assign fetch_count = 32'd0;
`endif

endmodule
